delay_line_prog: RTL and testbench

Parametrised, runtime-programmable delay line: a WIDTH-bit sample stream is delayed by D enabled clock cycles, where D (0..MAX_DELAY) is loaded at run time. It replaces fixed 1-bit shift-register delays. Storage is a circular buffer, not a shift chain. A fill counter drives an output-valid flag, so downstream logic never consumes samples left over from before a reset or a delay change.

---
 rtl/delay_line_pkg.sv | 19 +
 rtl/delay_line_prog_if.sv | 18 +
 rtl/delay_line_ram.sv | 21 ++
 rtl/delay_line_prog.sv | 69 ++++++
 tb/tb_delay_line_prog.sv | 127 ++++++++++++
 5 files changed

// File: rtl/delay_line_pkg.sv
// delay_line_pkg: shared width helpers and pointer arithmetic for the programmable delay line
package delay_line_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_MAX_DELAY = 16;

    function automatic int ptr_width(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

    function automatic int delay_width(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    function automatic int wrap_sub(input int a, input int b, input int m);
        return a < b ? a + m - b : a - b;
    endfunction

endpackage

// File: rtl/delay_line_prog_if.sv
// delay_line_prog_if: sample stream, delay programming and status signals of the delay line
interface delay_line_prog_if #(
    parameter int WIDTH     = 8,
    parameter int MAX_DELAY = 16
);
    import delay_line_pkg::*;
    localparam int DW = delay_width(MAX_DELAY);
    logic             en;
    logic [WIDTH-1:0] x;
    logic             delay_we;
    logic [DW-1:0]    delay;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             delay_err;
    logic [DW-1:0]    d_active;
    modport master (output en, x, delay_we, delay, input y, y_valid, delay_err, d_active);
    modport slave  (input en, x, delay_we, delay, output y, y_valid, delay_err, d_active);
endinterface

// File: rtl/delay_line_ram.sv
// delay_line_ram: DEPTH x WIDTH storage, synchronous write, asynchronous read, no reset
module delay_line_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // write port; contents deliberately survive reset
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/delay_line_prog.sv
// delay_line_prog: runtime-programmable circular-buffer delay line with fill-based valid
// Optional: DELAY_LINE_PROG_ZERO_FILL_EN forces y to zero while y_valid is low (bypass excepted)
module delay_line_prog
    import delay_line_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int MAX_DELAY     = 16,
    parameter int DEFAULT_DELAY = 4
) (
    input logic             clk,
    input logic             rst_n,
    delay_line_prog_if.slave bus
);
    localparam int PW = ptr_width(MAX_DELAY);
    localparam int DW = delay_width(MAX_DELAY);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [DW-1:0]    fill;
    logic [DW-1:0]    d_active;
    logic             delay_err;
    logic [WIDTH-1:0] raw;
    logic             bypass;
    logic             valid;

    delay_line_ram #(.WIDTH(WIDTH), .DEPTH(MAX_DELAY), .AW(PW)) u_ram (
        .clk   (clk),
        .we    (bus.en),
        .waddr (wr_ptr),
        .wdata (bus.x),
        .raddr (rd_ptr),
        .rdata (raw)
    );

    // pointer advance, saturating fill, delay load with clamp; a load restarts validity only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            fill      <= '0;
            d_active  <= DW'(DEFAULT_DELAY);
            delay_err <= 1'b0;
        end else begin
            delay_err <= bus.delay_we && (bus.delay > DW'(MAX_DELAY));
            if (bus.en) wr_ptr <= (wr_ptr == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr + PW'(1);
            if (bus.delay_we) begin
                d_active <= (bus.delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : bus.delay;
                fill     <= '0;
            end else if (bus.en && fill != DW'(MAX_DELAY)) begin
                fill <= fill + DW'(1);
            end
        end
    end

    // at D = MAX_DELAY the read lands on the slot about to be overwritten, which is the oldest sample
    always_comb begin
        rd_ptr = PW'(wrap_sub(int'(wr_ptr), int'(d_active), MAX_DELAY));
        bypass = d_active == '0;
        valid  = bypass || (fill >= d_active);
    end

    assign bus.y_valid   = valid;
    assign bus.delay_err = delay_err;
    assign bus.d_active  = d_active;
`ifdef DELAY_LINE_PROG_ZERO_FILL_EN
    assign bus.y = bypass ? bus.x : (valid ? raw : '0);
`else
    assign bus.y = bypass ? bus.x : raw;
`endif
endmodule

// File: tb/tb_delay_line_prog.sv
// tb_delay_line_prog: table vectors, directed corner sequences and random stream vs. a history-queue model
module tb_delay_line_prog;
    localparam int W  = 8;
    localparam int MD = 16;
    localparam int DD = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    delay_line_prog_if #(.WIDTH(W), .MAX_DELAY(MD)) b ();

    delay_line_prog #(.WIDTH(W), .MAX_DELAY(MD), .DEFAULT_DELAY(DD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    always #5 clk = ~clk;

    int hist[$];
    int cnt;
    int md;
    int merr;

    typedef struct {
        logic       en;
        logic [7:0] x;
        logic       we;
        logic [4:0] dv;
        logic       ev;
        logic [7:0] ey;
        logic [4:0] ed;
        logic       ee;
    } vec_t;

    vec_t vt[15];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
        end
    endtask

    task automatic check_model();
        logic ev;
        ev = (md == 0) || (cnt >= md);
        chk("y_valid", 32'(b.y_valid), 32'(ev));
        chk("d_active", 32'(b.d_active), 32'(md));
        chk("delay_err", 32'(b.delay_err), 32'(merr));
        if (md == 0) chk("y_bypass", 32'(b.y), 32'(b.x));
        else if (ev) chk("y_delayed", 32'(b.y), 32'(hist[hist.size() - md] & 8'hff));
    endtask

    task automatic model_edge(input logic e, input logic [7:0] xv, input logic we, input logic [4:0] dv);
        merr = (we && dv > MD) ? 1 : 0;
        if (e) hist.push_back(int'(xv));
        if (we) begin
            md  = dv > MD ? MD : int'(dv);
            cnt = 0;
        end else if (e) cnt++;
    endtask

    task automatic cyc(input logic e, input logic [7:0] xv, input logic we, input logic [4:0] dv);
        b.en = e; b.x = xv; b.delay_we = we; b.delay = dv;
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_edge(e, xv, we, dv);
        #1;
    endtask

    initial begin
        b.en = 0; b.x = 0; b.delay_we = 0; b.delay = 0;
        cnt = 0; md = DD; merr = 0;
        for (int i = 0; i < 12; i++)
            vt[i] = '{1'b1, 8'(i + 1), 1'b0, 5'd0, i >= 4, 8'(i - 3), 5'd4, 1'b0};
        vt[12] = '{1'b1, 8'd13, 1'b1, 5'd20, 1'b1, 8'd9, 5'd4, 1'b0};
        vt[13] = '{1'b1, 8'd14, 1'b0, 5'd0, 1'b0, 8'd0, 5'd16, 1'b1};
        vt[14] = '{1'b1, 8'd15, 1'b0, 5'd0, 1'b0, 8'd0, 5'd16, 1'b0};
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        for (int i = 0; i < 15; i++) begin
            b.en = vt[i].en; b.x = vt[i].x; b.delay_we = vt[i].we; b.delay = vt[i].dv;
            @(negedge clk);
            chk("tbl_valid", 32'(b.y_valid), 32'(vt[i].ev));
            chk("tbl_d_active", 32'(b.d_active), 32'(vt[i].ed));
            chk("tbl_err", 32'(b.delay_err), 32'(vt[i].ee));
            if (vt[i].ev) chk("tbl_y", 32'(b.y), 32'(vt[i].ey));
            check_model();
            @(posedge clk);
            model_edge(vt[i].en, vt[i].x, vt[i].we, vt[i].dv);
            #1;
        end
        // max delay across the pointer wrap
        for (int i = 0; i < 40; i++) cyc(1'b1, 8'($urandom), 1'b0, 5'd0);
        // bypass
        cyc(1'b1, 8'($urandom), 1'b1, 5'd0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'($urandom), 1'b0, 5'd0);
        // D=3 with gated enable
        cyc(1'b1, 8'h10, 1'b1, 5'd3);
        for (int i = 0; i < 24; i++) cyc(i % 3 == 0, 8'(8'h20 + i), 1'b0, 5'd0);
        // long run to exercise fill saturation
        cyc(1'b1, 8'($urandom), 1'b1, 5'd2);
        for (int i = 0; i < 80; i++) cyc(1'b1, 8'($urandom), 1'b0, 5'd0);
        // asynchronous reset between edges
        b.en = 1'b0; b.delay_we = 1'b0;
        #3 rst_n = 0;
        #1;
        chk("rst_valid", 32'(b.y_valid), 32'd0);
        chk("rst_d_active", 32'(b.d_active), 32'(DD));
        chk("rst_err", 32'(b.delay_err), 32'd0);
        @(posedge clk);
        #1 rst_n = 1;
        cnt = 0; md = DD; merr = 0;
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'($urandom), 1'b0, 5'd0);
        // random stream with occasional loads
        for (int i = 0; i < 800; i++)
            cyc(($urandom_range(3) != 0), 8'($urandom), ($urandom_range(49) == 0), 5'($urandom_range(20)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
